// File: rtl/imm_gen_pipe_if.sv
// -----------------------------------------------------------------------------
// imm_gen_pipe_if
//   Handshake bundle between decode (master) and the immediate generator
//   (slave).
//
//   Decode -> generator : inst, mode, in_valid, out_ready
//   Generator -> decode : in_ready, out, out_valid, count
// -----------------------------------------------------------------------------
interface imm_gen_pipe_if #(
    parameter int DATA_W = 16
);
    logic [DATA_W-1:0] inst;
    logic [1:0]        mode;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] out;
    logic              out_valid;
    logic              out_ready;
    logic [1:0]        count;

    modport master (
        output inst, mode, in_valid, out_ready,
        input  in_ready, out, out_valid, count
    );

    modport slave (
        input  inst, mode, in_valid, out_ready,
        output in_ready, out, out_valid, count
    );
endinterface

// File: rtl/imm_gen_pipe.sv
// -----------------------------------------------------------------------------
// imm_gen_pipe
//   Registered immediate generator. Extracts
//   inst[FIELD_LSB+FIELD_W-1:FIELD_LSB] and formats it by mode
//   (00 sign-extend, 01 zero-extend, 10 upper-place, 11 sign-extend + shift),
//   then holds results in a 2-entry FIFO with valid/ready on both sides.
//
//   clock : system clock, rising edge
//   reset : asynchronous, active-low
//   flush : synchronous clear of the buffer (wins over a same-cycle push)
//   bus   : imm_gen_pipe_if.slave (inst, mode, in_valid, in_ready,
//           out, out_valid, out_ready, count)
// -----------------------------------------------------------------------------
module imm_gen_pipe #(
    parameter int DATA_W      = 16,
    parameter int FIELD_W     = 8,
    parameter int FIELD_LSB   = 8,
    parameter int SHAMT_SX    = 1,
    parameter int UPPER_SHIFT = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               flush,
    imm_gen_pipe_if.slave      bus
);

    function automatic logic signed [DATA_W-1:0] sign_ext(input logic [FIELD_W-1:0] f);
        return {{(DATA_W-FIELD_W){f[FIELD_W-1]}}, f};
    endfunction

    function automatic logic [DATA_W-1:0] zero_ext(input logic [FIELD_W-1:0] f);
        return {{(DATA_W-FIELD_W){1'b0}}, f};
    endfunction

    // Shifts keep only the low DATA_W bits; overflow is silently dropped.
    function automatic logic signed [DATA_W-1:0] format_imm(input logic [FIELD_W-1:0] f,
                                                            input logic [1:0]         m);
        logic signed [DATA_W-1:0] r;
        case (m)
            2'b00:   r = sign_ext(f);
            2'b01:   r = zero_ext(f);
            2'b10:   r = zero_ext(f) << UPPER_SHIFT;
            default: r = sign_ext(f) << SHAMT_SX;
        endcase
        return r;
    endfunction

    // ---- stage p0: field extraction and formatting (combinational) ----
    logic [FIELD_W-1:0]       field_p0;
    logic signed [DATA_W-1:0] imm_p0;
    logic                     vld_p0;

    assign field_p0 = bus.inst[FIELD_LSB +: FIELD_W];
    assign imm_p0   = format_imm(field_p0, bus.mode);

    // ---- stage p1: 2-entry output buffer ----
    logic signed [DATA_W-1:0] mem_p1 [2];
    logic                     head_p1;
    logic                     tail_p1;
    logic [1:0]               count_p1;
    logic [1:0]               count_nxt;
    logic                     rdy_p1;
    logic                     vld_p1;
    logic                     pop;

    // in_ready is a register so out_ready never reaches it combinationally;
    // it also reads 0 while reset is held.
    assign vld_p0 = bus.in_valid && rdy_p1;
    assign vld_p1 = (count_p1 != 2'd0);
    assign pop    = vld_p1 && bus.out_ready;

    always_comb begin
        count_nxt = count_p1;
        case ({vld_p0, pop})
            2'b10:   count_nxt = count_p1 + 2'd1;
            2'b01:   count_nxt = count_p1 - 2'd1;
            default: count_nxt = count_p1;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_p1 <= 2'd0;
            head_p1  <= 1'b0;
            tail_p1  <= 1'b0;
            rdy_p1   <= 1'b0;
        end else if (flush) begin
            count_p1 <= 2'd0;
            head_p1  <= 1'b0;
            tail_p1  <= 1'b0;
            rdy_p1   <= 1'b1;
        end else begin
            if (vld_p0) tail_p1 <= ~tail_p1;
            if (pop)    head_p1 <= ~head_p1;
            count_p1 <= count_nxt;
            rdy_p1   <= (count_nxt != 2'd2);
        end
    end

    // Storage is never cleared; out is masked instead when the buffer is empty.
    always_ff @(posedge clock) begin
        if (vld_p0 && !flush) mem_p1[tail_p1] <= imm_p0;
    end

    assign bus.in_ready  = rdy_p1;
    assign bus.out_valid = vld_p1;
    assign bus.count     = count_p1;
    assign bus.out       = vld_p1 ? mem_p1[head_p1] : '0;

endmodule

// File: tb/tb_imm_gen_pipe.sv
module tb_imm_gen_pipe;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic flush = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clock = ~clock;

    imm_gen_pipe_if #(.DATA_W(16)) bus ();

    imm_gen_pipe #(
        .DATA_W(16), .FIELD_W(8), .FIELD_LSB(8), .SHAMT_SX(1), .UPPER_SHIFT(8)
    ) dut (
        .clock (clock),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        bus.inst      = '0;
        bus.mode      = 2'b00;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        flush         = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        #12;
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL rst_in_ready got=%b exp=0", bus.in_ready); end
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid got=%b exp=0", bus.out_valid); end
        n_cmp++; if (bus.count !== 2'd0) begin n_bad++; $display("FAIL rst_count got=%0d exp=0", bus.count); end
        n_cmp++; if (bus.out !== 16'h0000) begin n_bad++; $display("FAIL rst_out got=%h exp=0000", bus.out); end
        reset = 1'b1;
        tick();
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_release_ready got=%b exp=1", bus.in_ready); end
    endtask

    // Push one word, check it at the head one cycle later, then drain it.
    task automatic push_check(input logic [15:0] inst, input logic [1:0] mode,
                              input logic [15:0] exp, input string name);
        bus.inst = inst; bus.mode = mode; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        n_cmp++; if (bus.out !== exp) begin n_bad++; $display("FAIL %s out got=%h exp=%h", name, bus.out, exp); end
        n_cmp++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL %s out_valid got=%b exp=1", name, bus.out_valid); end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        n_cmp++; if (bus.count !== 2'd0) begin n_bad++; $display("FAIL %s drain count got=%0d exp=0", name, bus.count); end
    endtask

    task automatic test_formats();
        push_check(16'b0010010111111000, 2'b00, 16'h0025, "sx_pos");
        push_check(16'b1111001101011001, 2'b00, 16'hFFF3, "sx_neg");
        push_check(16'b0100101101100101, 2'b10, 16'h4B00, "upper");
        push_check(16'b0100101101100101, 2'b01, 16'h004B, "zx");
        push_check(16'hF300, 2'b11, 16'hFFE6, "sxsh_neg");
        push_check(16'h7F00, 2'b11, 16'h00FE, "sxsh_pos");
    endtask

    task automatic fill_two();
        bus.out_ready = 1'b0; bus.mode = 2'b00; bus.in_valid = 1'b1;
        bus.inst = 16'h2500;
        tick();
        bus.inst = 16'hF300;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        fill_two();
        n_cmp++; if (bus.count !== 2'd2) begin n_bad++; $display("FAIL bp_count got=%0d exp=2", bus.count); end
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready got=%b exp=0", bus.in_ready); end
        n_cmp++; if (bus.out !== 16'h0025) begin n_bad++; $display("FAIL bp_head got=%h exp=0025", bus.out); end
        // Offer a word while full: it must not enter.
        bus.inst = 16'h1100; bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        n_cmp++; if (bus.out !== 16'h0025) begin n_bad++; $display("FAIL bp_hold got=%h exp=0025", bus.out); end
        n_cmp++; if (bus.count !== 2'd2) begin n_bad++; $display("FAIL bp_hold_count got=%0d exp=2", bus.count); end
        bus.out_ready = 1'b1;
        tick();
        n_cmp++; if (bus.out !== 16'hFFF3) begin n_bad++; $display("FAIL bp_second got=%h exp=fff3", bus.out); end
        n_cmp++; if (bus.count !== 2'd1) begin n_bad++; $display("FAIL bp_count1 got=%0d exp=1", bus.count); end
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_ready_rise got=%b exp=1", bus.in_ready); end
        tick();
        bus.out_ready = 1'b0;
        n_cmp++; if (bus.count !== 2'd0) begin n_bad++; $display("FAIL bp_empty count got=%0d exp=0", bus.count); end
        n_cmp++; if (bus.out !== 16'h0000) begin n_bad++; $display("FAIL bp_empty out got=%h exp=0000", bus.out); end
    endtask

    task automatic test_back_to_back();
        bus.inst = 16'h1200; bus.mode = 2'b01; bus.in_valid = 1'b1;
        tick();
        n_cmp++; if (bus.out !== 16'h0012) begin n_bad++; $display("FAIL b2b_first got=%h exp=0012", bus.out); end
        bus.inst = 16'h3400; bus.out_ready = 1'b1;
        tick();
        n_cmp++; if (bus.count !== 2'd1) begin n_bad++; $display("FAIL b2b_count got=%0d exp=1", bus.count); end
        n_cmp++; if (bus.out !== 16'h0034) begin n_bad++; $display("FAIL b2b_next got=%h exp=0034", bus.out); end
        bus.in_valid = 1'b0;
        tick();
        bus.out_ready = 1'b0;
        n_cmp++; if (bus.count !== 2'd0) begin n_bad++; $display("FAIL b2b_drain got=%0d exp=0", bus.count); end
    endtask

    task automatic test_flush();
        fill_two();
        flush = 1'b1; bus.inst = 16'h5500; bus.in_valid = 1'b1;
        tick();
        flush = 1'b0; bus.in_valid = 1'b0;
        n_cmp++; if (bus.count !== 2'd0) begin n_bad++; $display("FAIL flush_count got=%0d exp=0", bus.count); end
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_valid got=%b exp=0", bus.out_valid); end
        n_cmp++; if (bus.out !== 16'h0000) begin n_bad++; $display("FAIL flush_out got=%h exp=0000", bus.out); end
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL flush_ready got=%b exp=1", bus.in_ready); end
        tick();
        n_cmp++; if (bus.count !== 2'd0) begin n_bad++; $display("FAIL flush_discard got=%0d exp=0", bus.count); end
        // Pointers are back at 0: next push lands at the head.
        push_check(16'h8000, 2'b00, 16'hFF80, "post_flush");
    endtask

    task automatic test_async_reset();
        fill_two();
        #3;
        reset = 1'b0;
        #1;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL arst_valid got=%b exp=0", bus.out_valid); end
        n_cmp++; if (bus.count !== 2'd0) begin n_bad++; $display("FAIL arst_count got=%0d exp=0", bus.count); end
        n_cmp++; if (bus.out !== 16'h0000) begin n_bad++; $display("FAIL arst_out got=%h exp=0000", bus.out); end
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL arst_ready got=%b exp=0", bus.in_ready); end
        tick();
        #2;
        reset = 1'b1;
        tick();
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL arst_release got=%b exp=1", bus.in_ready); end
        n_cmp++; if (bus.count !== 2'd0) begin n_bad++; $display("FAIL arst_release_count got=%0d exp=0", bus.count); end
    endtask

    initial begin
        test_reset();
        test_formats();
        test_backpressure();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
